// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM states, register offsets,
// STATUS field positions and the count saturation helper.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam logic [31:0] REG_RXDATA = 32'd0;
  localparam logic [31:0] REG_STATUS = 32'd1;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_OVERRUN   = 1;
  localparam int STAT_FRAME_ERR = 2;
  localparam int STAT_COUNT_LSB = 4;

  // The STATUS count field is only four bits wide, so deeper FIFOs report 15.
  function automatic logic [3:0] satCount(input logic [31:0] count);
    return (count > 32'd15) ? 4'hF : count[3:0];
  endfunction

endpackage

// File: rtl/uart_rx_byte_fifo.sv
// Byte-wide receive FIFO. A push while full is accepted only if a pop happens
// in the same cycle; a pop while empty is ignored.
module byte_fifo #(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_clr_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [7:0]    i_data,
  output logic [7:0]    o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [PW:0]   o_count
);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [PW:0]   r_count;
  logic          w_doPush;
  logic          w_doPop;

  assign o_full   = (r_count == (PW + 1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_data   = r_mem[r_rdPtr];
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  // Storage array; contents are don't-care until written, so it has no reset.
  always_ff @(posedge i_clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

  // Pointers wrap naturally at DEPTH; the count stays put on simultaneous push and pop.
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling 8N1 UART receiver with a byte FIFO behind a shared
// tristate bus exposing RXDATA (pop on read) and STATUS (write-1-to-clear flags).
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int          DIV       = 27,
  parameter int          DEPTH     = 8
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [31:0] BUS_addr,
  inout  wire  [31:0] BUS_data,
  input  logic        BUS_req,
  inout  wire         BUS_ready,
  input  logic        BUS_RW,
  input  logic        RxD,
  output logic        rx_irq
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  rx_state_e      r_state;
  rx_state_e      w_stateNext;
  logic           r_sync1, r_sync2, r_rxPrev;
  logic [DIV_W-1:0] r_divCnt;
  logic [3:0]     r_tickCnt;
  logic [2:0]     r_bitCnt;
  logic [7:0]     r_shift;
  logic           r_overrun, r_frameErr;
  logic           r_ack, r_busArmed;
  logic [31:0]    r_rdData;
  logic           w_fall, w_tick, w_midBit;
  logic           w_toData, w_sampleBit, w_stopDone;
  logic           w_push, w_pop, w_full, w_empty;
  logic [7:0]     w_head;
  logic [CW-1:0]  w_count;
  logic           w_isData, w_isStatus, w_sel, w_first, w_flagClr;
  logic           w_overrunSet, w_frameSet;
  logic [31:0]    w_status;
  logic           w_unused;

  assign w_fall   = r_rxPrev && !r_sync2;
  assign w_tick   = (r_divCnt == DIV_W'(DIV - 1));
  assign w_midBit = w_tick && (r_tickCnt == 4'd15);

  // Two-flop synchronizer plus one history flop for start-edge detection.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_rxPrev <= 1'b1;
    end else begin
      r_sync1  <= RxD;
      r_sync2  <= r_sync1;
      r_rxPrev <= r_sync2;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= ST_IDLE;
    else        r_state <= w_stateNext;
  end

  // Receiver next-state logic: mid-bit checks at tick 8 for start, every 16 ticks after.
  always_comb begin
    w_stateNext = r_state;
    w_toData    = 1'b0;
    w_sampleBit = 1'b0;
    w_stopDone  = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_fall) w_stateNext = ST_START;
      ST_START: begin
        if (w_tick && r_tickCnt == 4'd7) begin
          if (r_sync2) begin
            w_stateNext = ST_IDLE;
          end else begin
            w_stateNext = ST_DATA;
            w_toData    = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (w_midBit) begin
          w_sampleBit = 1'b1;
          if (r_bitCnt == 3'd7) w_stateNext = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_midBit) begin
          w_stopDone  = 1'b1;
          w_stateNext = ST_IDLE;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Tick divider and bit counters; held at zero in IDLE so they restart on entering START.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_divCnt  <= '0;
      r_tickCnt <= '0;
      r_bitCnt  <= '0;
      r_shift   <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_divCnt  <= '0;
        r_tickCnt <= '0;
      end else if (w_tick) begin
        r_divCnt  <= '0;
        r_tickCnt <= w_toData ? 4'd0 : r_tickCnt + 4'd1;
      end else begin
        r_divCnt  <= r_divCnt + 1'b1;
      end
      if (w_toData) r_bitCnt <= '0;
      if (w_sampleBit) begin
        r_shift  <= {r_sync2, r_shift[7:1]};
        r_bitCnt <= r_bitCnt + 3'd1;
      end
    end
  end

  assign w_isData   = (BUS_addr == BASE_ADDR + REG_RXDATA);
  assign w_isStatus = (BUS_addr == BASE_ADDR + REG_STATUS);
  assign w_sel      = r_busArmed && BUS_req && (w_isData || w_isStatus);
  assign w_first    = w_sel && !r_ack;
  assign w_pop      = w_first && !BUS_RW && w_isData && !w_empty;
  assign w_flagClr  = w_first && BUS_RW && w_isStatus;

  assign w_push       = w_stopDone && r_sync2;
  assign w_overrunSet = w_push && w_full && !w_pop;
  assign w_frameSet   = w_stopDone && !r_sync2;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_clr_n (clr_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (r_shift),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // STATUS word assembled from live FIFO state and sticky flags.
  always_comb begin
    w_status = '0;
    w_status[STAT_NOT_EMPTY] = !w_empty;
    w_status[STAT_OVERRUN]   = r_overrun;
    w_status[STAT_FRAME_ERR] = r_frameErr;
    w_status[STAT_COUNT_LSB +: 4] = satCount(32'(w_count));
  end

  // Sticky error flags; a hardware set beats a same-cycle software clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_overrun  <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      if (w_overrunSet) r_overrun <= 1'b1;
      else if (w_flagClr && BUS_data[STAT_OVERRUN]) r_overrun <= 1'b0;
      if (w_frameSet) r_frameErr <= 1'b1;
      else if (w_flagClr && BUS_data[STAT_FRAME_ERR]) r_frameErr <= 1'b0;
    end
  end

  // Bus handshake: acknowledge one cycle after selection, latch read data once per
  // transaction, and ignore requests held across reset until the bus has been seen idle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_ack      <= 1'b0;
      r_busArmed <= 1'b0;
      r_rdData   <= '0;
    end else begin
      r_ack <= w_sel;
      if (!BUS_req) r_busArmed <= 1'b1;
      if (w_first && !BUS_RW) begin
        if (w_isData) r_rdData <= w_empty ? 32'd0 : {24'd0, w_head};
        else          r_rdData <= w_status;
      end
    end
  end

  assign BUS_ready = (r_ack && w_sel) ? 1'b1 : 1'bz;
  assign BUS_data  = (r_ack && w_sel && !BUS_RW) ? r_rdData : 32'bz;
  assign rx_irq    = !w_empty || r_overrun || r_frameErr;
  assign w_unused  = ^{BUS_data[31:3], BUS_data[0]};

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx, compared against a byte-level
// queue model of the receive FIFO and its error flags.
module tb_uart_rx;

  localparam int          TB_DIV    = 4;
  localparam int          TB_DEPTH  = 8;
  localparam int          BIT_CLKS  = 16 * TB_DIV;
  localparam logic [31:0] BASE      = 32'h0000_0100;
  localparam logic [31:0] ADDR_DATA = BASE;
  localparam logic [31:0] ADDR_STAT = BASE + 32'd1;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic [31:0] BUS_addr = '0;
  logic        BUS_req = 1'b0;
  logic        BUS_RW = 1'b0;
  logic        RxD = 1'b1;
  wire  [31:0] BUS_data;
  wire         BUS_ready;
  wire         rx_irq;
  logic        tbDrive = 1'b0;
  logic [31:0] tbData = '0;

  int checks = 0;
  int failures = 0;

  logic [7:0] modelQ[$];
  bit         mOverrun = 1'b0;
  bit         mFrame = 1'b0;

  assign BUS_data = tbDrive ? tbData : 32'bz;

  uart_rx #(.BASE_ADDR(BASE), .DIV(TB_DIV), .DEPTH(TB_DEPTH)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .BUS_addr  (BUS_addr),
    .BUS_data  (BUS_data),
    .BUS_req   (BUS_req),
    .BUS_ready (BUS_ready),
    .BUS_RW    (BUS_RW),
    .RxD       (RxD),
    .rx_irq    (rx_irq)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and log any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] modelStatus();
    int c;
    c = modelQ.size();
    if (c > 15) c = 15;
    return {24'd0, 4'(c), 1'b0, mFrame, mOverrun, (modelQ.size() != 0)};
  endfunction

  function automatic logic [31:0] modelPop();
    if (modelQ.size() == 0) return 32'd0;
    return {24'd0, modelQ.pop_front()};
  endfunction

  function automatic logic [31:0] modelIrq();
    return {31'd0, (modelQ.size() != 0) || mOverrun || mFrame};
  endfunction

  function automatic void modelFrame(input logic [7:0] b, input logic stopBit);
    if (!stopBit)                        mFrame = 1'b1;
    else if (modelQ.size() < TB_DEPTH)   modelQ.push_back(b);
    else                                 mOverrun = 1'b1;
  endfunction

  // Send one 8N1 frame, LSB first, with a chosen stop-bit level, then idle briefly.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    RxD = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    RxD = stopBit;
    repeat (BIT_CLKS) @(negedge clk);
    RxD = 1'b1;
    repeat (8) @(negedge clk);
    modelFrame(b, stopBit);
  endtask

  task automatic busRead(input logic [31:0] addr, input string tag, output logic [31:0] data);
    BUS_addr = addr;
    BUS_RW   = 1'b0;
    BUS_req  = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_ready"}, {31'd0, BUS_ready === 1'b1}, 32'd1);
    data    = BUS_data;
    BUS_req = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_release"}, {31'd0, BUS_ready === 1'b1}, 32'd0);
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data, input string tag);
    BUS_addr = addr;
    BUS_RW   = 1'b1;
    tbData   = data;
    tbDrive  = 1'b1;
    BUS_req  = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_ready"}, {31'd0, BUS_ready === 1'b1}, 32'd1);
    BUS_req = 1'b0;
    tbDrive = 1'b0;
    BUS_RW  = 1'b0;
    @(negedge clk);
    if (addr == ADDR_STAT) begin
      if (data[1]) mOverrun = 1'b0;
      if (data[2]) mFrame = 1'b0;
    end
  endtask

  task automatic readStatus(input string tag);
    logic [31:0] d;
    busRead(ADDR_STAT, tag, d);
    checkOutput(tag, d, modelStatus());
  endtask

  task automatic readData(input string tag);
    logic [31:0] d;
    busRead(ADDR_DATA, tag, d);
    checkOutput(tag, d, modelPop());
  endtask

  task automatic checkIrq(input string tag);
    checkOutput(tag, {31'd0, rx_irq}, modelIrq());
  endtask

  // Directed sequence followed by a randomized traffic phase.
  initial begin
    logic [7:0]  b0, b1;
    logic [31:0] d;
    int          readyCnt;

    // Reset held from time zero; outputs must be quiet before any clock.
    #1;
    checkOutput("reset_irq", {31'd0, rx_irq}, 32'd0);
    checkOutput("reset_ready", {31'd0, BUS_ready === 1'b1}, 32'd0);
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    repeat (4) @(negedge clk);
    readStatus("reset_status");

    // Single byte round trip.
    applyStimulus(8'hA5, 1'b1);
    checkIrq("a5_irq_set");
    readStatus("a5_status");
    readData("a5_data");
    readStatus("a5_status_after");
    checkIrq("a5_irq_clear");

    // Nine bytes with no reads: the ninth overflows.
    for (int i = 1; i <= 9; i++) applyStimulus(8'(i), 1'b1);
    readStatus("ovr_status");
    for (int i = 1; i <= 8; i++) readData($sformatf("ovr_data%0d", i));
    readData("ovr_empty_read");
    busWrite(ADDR_STAT, 32'h2, "ovr_clear");
    readStatus("ovr_status_cleared");

    // Short low glitch must be rejected; a clean byte afterwards must still arrive.
    RxD = 1'b0;
    repeat (2 * TB_DIV) @(negedge clk);
    RxD = 1'b1;
    repeat (BIT_CLKS * 2) @(negedge clk);
    readStatus("glitch_status");
    checkIrq("glitch_irq");
    b0 = 8'($urandom);
    applyStimulus(b0, 1'b1);
    readData("glitch_next_data");

    // Framing error, then selective clears.
    applyStimulus(8'h3C, 1'b0);
    readStatus("frame_status");
    checkIrq("frame_irq");
    busWrite(ADDR_STAT, 32'h2, "frame_wrong_clear");
    readStatus("frame_still_set");
    busWrite(ADDR_DATA, 32'h4, "frame_rxdata_write");
    readStatus("frame_rxdata_ignored");
    busWrite(ADDR_STAT, 32'h4, "frame_clear");
    readStatus("frame_cleared");

    // Reset in the middle of a data bit, with one byte already queued.
    b0 = 8'($urandom);
    applyStimulus(b0, 1'b1);
    RxD = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      RxD = ~RxD;
      repeat (BIT_CLKS) @(negedge clk);
    end
    RxD = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    clr_n = 1'b0;
    #1;
    checkOutput("midreset_irq", {31'd0, rx_irq}, 32'd0);
    modelQ.delete();
    mOverrun = 1'b0;
    mFrame = 1'b0;
    RxD = 1'b1;
    @(negedge clk);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    repeat (BIT_CLKS * 10) @(negedge clk);
    readStatus("midreset_status");
    applyStimulus(8'h7E, 1'b1);
    readData("midreset_7e");

    // Long-held RXDATA read pops exactly once.
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    applyStimulus(b0, 1'b1);
    applyStimulus(b1, 1'b1);
    BUS_addr = ADDR_DATA;
    BUS_RW   = 1'b0;
    BUS_req  = 1'b1;
    readyCnt = 0;
    d = '0;
    for (int i = 0; i < 5; i++) begin
      if (BUS_ready === 1'b1) readyCnt++;
      if (i == 1) d = BUS_data;
      @(negedge clk);
    end
    BUS_req = 1'b0;
    checkOutput("hold_ready_cycles", 32'(readyCnt), 32'd4);
    checkOutput("hold_data", d, modelPop());
    @(negedge clk);
    checkOutput("hold_release", {31'd0, BUS_ready === 1'b1}, 32'd0);
    readStatus("hold_status");
    readData("hold_second");

    // Randomized traffic with occasional bad stop bits and interleaved reads.
    for (int n = 0; n < 14; n++) begin
      b0 = 8'($urandom);
      applyStimulus(b0, ($urandom_range(0, 7) != 0));
      if ($urandom_range(0, 2) == 0) readStatus($sformatf("rand_status%0d", n));
      if ($urandom_range(0, 2) == 0) readData($sformatf("rand_data%0d", n));
      checkIrq($sformatf("rand_irq%0d", n));
    end
    readStatus("rand_final_status");
    while (modelQ.size() > 0) readData("rand_drain");
    busWrite(ADDR_STAT, 32'h6, "rand_clear");
    readStatus("rand_end_status");
    checkIrq("rand_end_irq");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
